// File: rtl/csr_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : csr_access_arbiter
// Description : Owner of the single CSR register-file access port. Shares the
//               port between the EXU CSR-instruction path and the trap /
//               interrupt controller, and runs the multi-cycle CSR write
//               sequences for trap entry (mepc, mcause, mstatus, mtvec fetch)
//               and for mret (mstatus restore, mepc fetch).
//
// Ports       : clk, rst            - core clock, synchronous active-high reset
//               exu_req_i/addr/we/wdata, exu_gnt_o, exu_rdata_o
//                                   - single-cycle combinational EXU access
//               trap_req_i, trap_pc_i, trap_cause_i, trap_ack_o
//                                   - trap-entry handshake (held until ack)
//               mret_req_i, mret_ack_o
//                                   - mret handshake (held until ack)
//               done_o, target_pc_o - sequence completion and redirect PC
//               busy_o              - high while a sequence is running
//               csr_raddr_o, csr_rdata_i, csr_we_o, csr_waddr_o, csr_wdata_o
//                                   - CSR register-file port (comb. read)
//
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_arbiter #(
    parameter int CSR_ADDR_W = 12,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // EXU CSR-instruction path
    input  logic                  exu_req_i,
    input  logic [CSR_ADDR_W-1:0] exu_addr_i,
    input  logic                  exu_we_i,
    input  logic [XLEN-1:0]       exu_wdata_i,
    output logic                  exu_gnt_o,
    output logic [XLEN-1:0]       exu_rdata_o,

    // Trap / interrupt controller
    input  logic                  trap_req_i,
    input  logic [XLEN-1:0]       trap_pc_i,
    input  logic [XLEN-1:0]       trap_cause_i,
    input  logic                  mret_req_i,
    output logic                  trap_ack_o,
    output logic                  mret_ack_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       target_pc_o,
    output logic                  busy_o,

    // CSR register-file port
    output logic [CSR_ADDR_W-1:0] csr_raddr_o,
    input  logic [XLEN-1:0]       csr_rdata_i,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [XLEN-1:0]       csr_wdata_o
);

    // ------------------------------------------------------------------------
    // Fixed CSR addresses and mstatus field positions
    // ------------------------------------------------------------------------
    localparam logic [CSR_ADDR_W-1:0] c_addr_mstatus = CSR_ADDR_W'(12'h300);
    localparam logic [CSR_ADDR_W-1:0] c_addr_mtvec   = CSR_ADDR_W'(12'h305);
    localparam logic [CSR_ADDR_W-1:0] c_addr_mepc    = CSR_ADDR_W'(12'h341);
    localparam logic [CSR_ADDR_W-1:0] c_addr_mcause  = CSR_ADDR_W'(12'h342);

    localparam int c_mie_bit    = 3;
    localparam int c_mpie_bit   = 7;
    localparam int c_mpp_lo_bit = 11;
    localparam int c_mpp_hi_bit = 12;

    // ------------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_t_epc   = 3'd1;
    localparam logic [2:0] c_st_t_cause = 3'd2;
    localparam logic [2:0] c_st_t_stat  = 3'd3;
    localparam logic [2:0] c_st_t_vec   = 3'd4;
    localparam logic [2:0] c_st_m_stat  = 3'd5;
    localparam logic [2:0] c_st_m_vec   = 3'd6;

    // Write-data source selector
    localparam logic [2:0] c_wsel_none      = 3'd0;
    localparam logic [2:0] c_wsel_exu       = 3'd1;
    localparam logic [2:0] c_wsel_pc        = 3'd2;
    localparam logic [2:0] c_wsel_cause     = 3'd3;
    localparam logic [2:0] c_wsel_stat_trap = 3'd4;
    localparam logic [2:0] c_wsel_stat_mret = 3'd5;

    // Redirect-PC source selector
    localparam logic [1:0] c_tsel_none = 2'd0;
    localparam logic [1:0] c_tsel_vec  = 2'd1;
    localparam logic [1:0] c_tsel_epc  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [XLEN-1:0] r_trap_pc;
    logic [XLEN-1:0] r_trap_cause;

    logic [2:0]      w_next_state;
    logic            w_trap_take;
    logic [2:0]      w_wsel;
    logic [1:0]      w_tsel;
    logic [XLEN-1:0] w_stat_trap;
    logic [XLEN-1:0] w_stat_mret;

    // ------------------------------------------------------------------------
    // Control decode. Deliberately free of any CSR read data so that the
    // combinational read path (raddr -> CSR file -> rdata -> EXU -> wdata)
    // never folds back into this block.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_trap_take  = 1'b0;
        w_wsel       = c_wsel_none;
        w_tsel       = c_tsel_none;
        trap_ack_o   = 1'b0;
        mret_ack_o   = 1'b0;
        exu_gnt_o    = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_raddr_o  = '0;

        // During the reset cycle every output stays 0 and requests are ignored.
        if (!rst) begin
            busy_o = (r_state != c_st_idle);
            case (r_state)
                c_st_idle: begin
                    if (trap_req_i) begin
                        trap_ack_o   = 1'b1;
                        w_trap_take  = 1'b1;
                        w_next_state = c_st_t_epc;
                    end else if (mret_req_i) begin
                        mret_ack_o   = 1'b1;
                        w_next_state = c_st_m_stat;
                    end else if (exu_req_i) begin
                        exu_gnt_o   = 1'b1;
                        csr_raddr_o = exu_addr_i;
                        if (exu_we_i) begin
                            csr_we_o    = 1'b1;
                            csr_waddr_o = exu_addr_i;
                            w_wsel      = c_wsel_exu;
                        end
                    end
                end
                c_st_t_epc: begin
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = c_addr_mepc;
                    w_wsel       = c_wsel_pc;
                    w_next_state = c_st_t_cause;
                end
                c_st_t_cause: begin
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = c_addr_mcause;
                    w_wsel       = c_wsel_cause;
                    w_next_state = c_st_t_stat;
                end
                c_st_t_stat: begin
                    csr_raddr_o  = c_addr_mstatus;
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = c_addr_mstatus;
                    w_wsel       = c_wsel_stat_trap;
                    w_next_state = c_st_t_vec;
                end
                c_st_t_vec: begin
                    csr_raddr_o  = c_addr_mtvec;
                    done_o       = 1'b1;
                    w_tsel       = c_tsel_vec;
                    w_next_state = c_st_idle;
                end
                c_st_m_stat: begin
                    csr_raddr_o  = c_addr_mstatus;
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = c_addr_mstatus;
                    w_wsel       = c_wsel_stat_mret;
                    w_next_state = c_st_m_vec;
                end
                c_st_m_vec: begin
                    csr_raddr_o  = c_addr_mepc;
                    done_o       = 1'b1;
                    w_tsel       = c_tsel_epc;
                    w_next_state = c_st_idle;
                end
                default: begin
                    w_next_state = c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // EXU read data: only meaningful (non-zero) while the EXU is granted.
    // ------------------------------------------------------------------------
    assign exu_rdata_o = exu_gnt_o ? csr_rdata_i : '0;

    // ------------------------------------------------------------------------
    // mstatus read-modify-write values for trap entry and mret.
    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    // mret      : MIE <- MPIE, MPIE <- 1, MPP stays M (machine-only core).
    // ------------------------------------------------------------------------
    always_comb begin
        w_stat_trap                            = csr_rdata_i;
        w_stat_trap[c_mpie_bit]                = csr_rdata_i[c_mie_bit];
        w_stat_trap[c_mie_bit]                 = 1'b0;
        w_stat_trap[c_mpp_hi_bit:c_mpp_lo_bit] = 2'b11;

        w_stat_mret                            = csr_rdata_i;
        w_stat_mret[c_mie_bit]                 = csr_rdata_i[c_mpie_bit];
        w_stat_mret[c_mpie_bit]                = 1'b1;
        w_stat_mret[c_mpp_hi_bit:c_mpp_lo_bit] = 2'b11;
    end

    // ------------------------------------------------------------------------
    // Write-data and redirect-PC muxes
    // ------------------------------------------------------------------------
    always_comb begin
        csr_wdata_o = '0;
        case (w_wsel)
            c_wsel_exu:       csr_wdata_o = exu_wdata_i;
            c_wsel_pc:        csr_wdata_o = r_trap_pc;
            c_wsel_cause:     csr_wdata_o = r_trap_cause;
            c_wsel_stat_trap: csr_wdata_o = w_stat_trap;
            c_wsel_stat_mret: csr_wdata_o = w_stat_mret;
            default:          csr_wdata_o = '0;
        endcase
    end

    always_comb begin
        target_pc_o = '0;
        case (w_tsel)
            // Trap vector is forced to direct mode (4-byte aligned base).
            c_tsel_vec: target_pc_o = {csr_rdata_i[XLEN-1:2], 2'b00};
            c_tsel_epc: target_pc_o = csr_rdata_i;
            default:    target_pc_o = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state. Trap operands are captured at acknowledge so that
    // later changes on the trap inputs cannot disturb a running sequence.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_trap_take) begin
                r_trap_pc    <= trap_pc_i;
                r_trap_cause <= trap_cause_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_arbiter
// Description : Self-checking bench for csr_access_arbiter. Provides a CSR
//               register-file model behind the DUT port and a separate
//               reference view of expected CSR contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_arbiter;

    localparam int AW = 12;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          exu_req_i, exu_we_i, exu_gnt_o;
    logic [AW-1:0] exu_addr_i;
    logic [XL-1:0] exu_wdata_i, exu_rdata_o;
    logic          trap_req_i, mret_req_i, trap_ack_o, mret_ack_o, done_o, busy_o;
    logic [XL-1:0] trap_pc_i, trap_cause_i, target_pc_o;
    logic [AW-1:0] csr_raddr_o, csr_waddr_o;
    logic [XL-1:0] csr_rdata_i, csr_wdata_o;
    logic          csr_we_o;

    always #5 clk = ~clk;

    csr_access_arbiter #(.CSR_ADDR_W(AW), .XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .exu_req_i(exu_req_i), .exu_addr_i(exu_addr_i), .exu_we_i(exu_we_i),
        .exu_wdata_i(exu_wdata_i), .exu_gnt_o(exu_gnt_o), .exu_rdata_o(exu_rdata_o),
        .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
        .mret_req_i(mret_req_i), .trap_ack_o(trap_ack_o), .mret_ack_o(mret_ack_o),
        .done_o(done_o), .target_pc_o(target_pc_o), .busy_o(busy_o),
        .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o)
    );

    // CSR register file behind the DUT port, plus a backdoor for preloading.
    logic [XL-1:0] csr_mem [0:4095];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [XL-1:0] bd_data;
    assign csr_rdata_i = csr_mem[csr_raddr_o];
    always @(posedge clk) begin
        if (csr_we_o) csr_mem[csr_waddr_o] <= csr_wdata_o;
        else if (bd_we) csr_mem[bd_addr] <= bd_data;
    end

    // EXU write data: either a constant or a read-modify-write of the read data.
    logic          exu_rmw;
    logic [XL-1:0] exu_mask, exu_wconst;
    assign exu_wdata_i = exu_rmw ? (exu_rdata_o ^ exu_mask) : exu_wconst;

    // Reference view of architectural CSR contents.
    logic [XL-1:0] ref_csr [0:4095];

    // {trap_ack, mret_ack, done, busy, exu_gnt, csr_we}
    logic [5:0] ctl;
    assign ctl = {trap_ack_o, mret_ack_o, done_o, busy_o, exu_gnt_o, csr_we_o};

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [AW-1:0] A_MSTATUS = 12'h300;
    localparam logic [AW-1:0] A_MTVEC   = 12'h305;
    localparam logic [AW-1:0] A_MEPC    = 12'h341;
    localparam logic [AW-1:0] A_MCAUSE  = 12'h342;

    // Architectural mstatus updates (MIE=bit3, MPIE=bit7, MPP=bits12:11).
    function automatic logic [XL-1:0] trap_status(input logic [XL-1:0] m);
        logic [XL-1:0] mie;
        mie = (m >> 3) & 32'h1;
        return (m & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
    endfunction

    function automatic logic [XL-1:0] mret_status(input logic [XL-1:0] m);
        logic [XL-1:0] mpie;
        mpie = (m >> 7) & 32'h1;
        return (m & ~32'h0000_1888) | (mpie << 3) | 32'h0000_0080 | 32'h0000_1800;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exu_req_i = 1'b0; exu_we_i = 1'b0; exu_addr_i = '0;
        exu_rmw = 1'b0; exu_mask = '0; exu_wconst = '0;
        trap_req_i = 1'b0; mret_req_i = 1'b0;
    endtask

    task automatic set_csr(input logic [AW-1:0] a, input logic [XL-1:0] d);
        idle_inputs();
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        next_cycle();
        bd_we = 1'b0;
        ref_csr[a] = d;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        trap_req_i = 1'b1; mret_req_i = 1'b1; exu_req_i = 1'b1; exu_we_i = 1'b1;
        exu_addr_i = 12'h340; exu_wconst = 32'hFFFF_FFFF;
        trap_pc_i = 32'hAAAA_AAAA; trap_cause_i = 32'h5555_5555;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== 6'b0) begin
                n_bad++; $display("FAIL reset_ctl c%0d: got %b want 000000", c, ctl);
            end
            n_cmp++;
            if ({csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o, exu_rdata_o} !== '0) begin
                n_bad++;
                $display("FAIL reset_data c%0d: raddr %h waddr %h wdata %h tgt %h rdata %h want 0",
                         c, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o, exu_rdata_o);
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_bad++; $display("FAIL reset_idle: got %b want 000000", ctl);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_exu_rmw();
        set_csr(12'h340, 32'h0);
        exu_req_i = 1'b1; exu_addr_i = 12'h340; exu_we_i = 1'b1;
        exu_rmw = 1'b0; exu_wconst = 32'hA5;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 6'b000011) begin
            n_bad++; $display("FAIL exu_wr_ctl: got %b want 000011", ctl);
        end
        n_cmp++;
        if ({csr_raddr_o, csr_waddr_o, csr_wdata_o} !== {12'h340, 12'h340, 32'hA5}) begin
            n_bad++;
            $display("FAIL exu_wr_port: raddr %h waddr %h wdata %h want 340 340 a5",
                     csr_raddr_o, csr_waddr_o, csr_wdata_o);
        end
        next_cycle();
        exu_rmw = 1'b1; exu_mask = 32'hFF;
        @(negedge clk);
        n_cmp++;
        if ({exu_gnt_o, exu_rdata_o, csr_wdata_o} !== {1'b1, 32'hA5, 32'h5A}) begin
            n_bad++;
            $display("FAIL exu_rmw: gnt %b rdata %h wdata %h want 1 a5 5a",
                     exu_gnt_o, exu_rdata_o, csr_wdata_o);
        end
        next_cycle();
        exu_we_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, exu_rdata_o, csr_waddr_o, csr_wdata_o} !== {6'b000010, 32'h5A, 12'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL exu_rd_back: ctl %b rdata %h waddr %h wdata %h want 000010 5a 0 0",
                     ctl, exu_rdata_o, csr_waddr_o, csr_wdata_o);
        end
        next_cycle();
        ref_csr[12'h340] = 32'h5A;
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_exu_random();
        logic [AW-1:0] addrs [4];
        logic [AW-1:0] a;
        logic          req, we;
        logic [XL-1:0] exp_rd, exp_wd;
        addrs[0] = 12'h340; addrs[1] = 12'h344; addrs[2] = 12'h7C0; addrs[3] = 12'hB00;
        for (int i = 0; i < 4; i++) set_csr(addrs[i], $urandom);
        for (int i = 0; i < 40; i++) begin
            req = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1) == 1;
            a   = addrs[$urandom_range(0, 3)];
            exu_req_i = req; exu_we_i = we; exu_addr_i = a;
            exu_rmw = $urandom_range(0, 1) == 1; exu_mask = $urandom; exu_wconst = $urandom;
            exp_rd = req ? ref_csr[a] : '0;
            exp_wd = (req && we) ? (exu_rmw ? (ref_csr[a] ^ exu_mask) : exu_wconst) : '0;
            @(negedge clk);
            n_cmp++;
            if ({ctl, exu_rdata_o, csr_waddr_o, csr_wdata_o} !==
                {4'b0000, req, req & we, exp_rd, (req && we) ? a : 12'h0, exp_wd}) begin
                n_bad++;
                $display("FAIL exu_rand i%0d: ctl %b rdata %h waddr %h wdata %h want gnt %b we %b rdata %h wdata %h",
                         i, ctl, exu_rdata_o, csr_waddr_o, csr_wdata_o, req, req & we, exp_rd, exp_wd);
            end
            next_cycle();
            if (req && we) ref_csr[a] = exp_wd;
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    // Trap entry: ack in cycle 0, writes in cycles 1..3, done in cycle 4.
    task automatic test_trap(input logic [XL-1:0] pc, input logic [XL-1:0] cause,
                             input logic change_after, input logic exu_contend);
        logic [5:0]    e_ctl;
        logic [AW-1:0] e_ra, e_wa;
        logic [XL-1:0] e_wd, e_tg, e_stat;
        e_stat = trap_status(ref_csr[A_MSTATUS]);
        trap_req_i = 1'b1; trap_pc_i = pc; trap_cause_i = cause;
        exu_req_i = exu_contend; exu_addr_i = 12'h340; exu_we_i = 1'b1; exu_wconst = 32'h1;
        for (int c = 0; c < 5; c++) begin
            e_ctl = 6'b000101; e_ra = '0; e_wa = '0; e_wd = '0; e_tg = '0;
            case (c)
                0: e_ctl = 6'b100000;
                1: begin e_wa = A_MEPC;   e_wd = pc; end
                2: begin e_wa = A_MCAUSE; e_wd = cause; end
                3: begin e_ra = A_MSTATUS; e_wa = A_MSTATUS; e_wd = e_stat; end
                default: begin
                    e_ctl = 6'b001100; e_ra = A_MTVEC;
                    e_tg = ref_csr[A_MTVEC] & ~32'h3;
                end
            endcase
            @(negedge clk);
            n_cmp++;
            if ({ctl, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o} !== {e_ctl, e_ra, e_wa, e_wd, e_tg}) begin
                n_bad++;
                $display("FAIL trap c%0d: ctl %b raddr %h waddr %h wdata %h tgt %h want %b %h %h %h %h",
                         c, ctl, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o,
                         e_ctl, e_ra, e_wa, e_wd, e_tg);
            end
            next_cycle();
            if (c == 0) begin
                trap_req_i = 1'b0; exu_req_i = 1'b0;
                if (change_after) begin
                    trap_pc_i = ~pc; trap_cause_i = $urandom;
                end
            end
        end
        ref_csr[A_MEPC] = pc; ref_csr[A_MCAUSE] = cause; ref_csr[A_MSTATUS] = e_stat;
        n_cmp++;
        if ({csr_mem[A_MEPC], csr_mem[A_MCAUSE], csr_mem[A_MSTATUS]} !== {pc, cause, e_stat}) begin
            n_bad++;
            $display("FAIL trap_csrs: mepc %h mcause %h mstatus %h want %h %h %h",
                     csr_mem[A_MEPC], csr_mem[A_MCAUSE], csr_mem[A_MSTATUS], pc, cause, e_stat);
        end
    endtask

    // ------------------------------------------------------------------------
    // mret: ack in cycle 0, mstatus write in cycle 1, done in cycle 2.
    task automatic test_mret();
        logic [5:0]    e_ctl;
        logic [AW-1:0] e_ra, e_wa;
        logic [XL-1:0] e_wd, e_tg, e_stat;
        e_stat = mret_status(ref_csr[A_MSTATUS]);
        mret_req_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            e_ctl = 6'b010000; e_ra = '0; e_wa = '0; e_wd = '0; e_tg = '0;
            if (c == 1) begin e_ctl = 6'b000101; e_ra = A_MSTATUS; e_wa = A_MSTATUS; e_wd = e_stat; end
            if (c == 2) begin e_ctl = 6'b001100; e_ra = A_MEPC; e_tg = ref_csr[A_MEPC]; end
            @(negedge clk);
            n_cmp++;
            if ({ctl, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o} !== {e_ctl, e_ra, e_wa, e_wd, e_tg}) begin
                n_bad++;
                $display("FAIL mret c%0d: ctl %b raddr %h waddr %h wdata %h tgt %h want %b %h %h %h %h",
                         c, ctl, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o,
                         e_ctl, e_ra, e_wa, e_wd, e_tg);
            end
            next_cycle();
            if (c == 0) mret_req_i = 1'b0;
        end
        ref_csr[A_MSTATUS] = e_stat;
    endtask

    // ------------------------------------------------------------------------
    // All three requesters at once: trap, then mret, then EXU.
    task automatic test_contention();
        logic [5:0]    e_ctl [9];
        logic [XL-1:0] pc, e_stat;
        pc = $urandom & ~32'h3;
        e_ctl[0] = 6'b100000; e_ctl[1] = 6'b000101; e_ctl[2] = 6'b000101;
        e_ctl[3] = 6'b000101; e_ctl[4] = 6'b001100; e_ctl[5] = 6'b010000;
        e_ctl[6] = 6'b000101; e_ctl[7] = 6'b001100; e_ctl[8] = 6'b000010;
        e_stat = mret_status(trap_status(ref_csr[A_MSTATUS]));
        trap_req_i = 1'b1; mret_req_i = 1'b1; trap_pc_i = pc; trap_cause_i = 32'h7;
        exu_req_i = 1'b1; exu_we_i = 1'b0; exu_addr_i = 12'h340;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== e_ctl[c]) begin
                n_bad++; $display("FAIL contention c%0d: ctl %b want %b", c, ctl, e_ctl[c]);
            end
            if (c == 4 || c == 7) begin
                n_cmp++;
                if (target_pc_o !== ((c == 4) ? (ref_csr[A_MTVEC] & ~32'h3) : pc)) begin
                    n_bad++; $display("FAIL contention_tgt c%0d: got %h", c, target_pc_o);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (exu_rdata_o !== ref_csr[12'h340]) begin
                    n_bad++; $display("FAIL contention_exu: rdata %h want %h", exu_rdata_o, ref_csr[12'h340]);
                end
            end
            next_cycle();
            if (c == 0) trap_req_i = 1'b0;
            if (c == 5) mret_req_i = 1'b0;
        end
        idle_inputs();
        ref_csr[A_MEPC] = pc; ref_csr[A_MCAUSE] = 32'h7; ref_csr[A_MSTATUS] = e_stat;
        n_cmp++;
        if (csr_mem[A_MSTATUS] !== e_stat) begin
            n_bad++; $display("FAIL contention_mstatus: got %h want %h", csr_mem[A_MSTATUS], e_stat);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_trap();
        set_csr(A_MSTATUS, 32'h8);
        set_csr(A_MCAUSE, 32'hDEAD);
        set_csr(A_MEPC, 32'h0);
        trap_req_i = 1'b1; trap_pc_i = 32'h1234; trap_cause_i = 32'hB;
        next_cycle();                      // cycle 0: ack
        trap_req_i = 1'b0;
        @(negedge clk);                    // cycle 1: mepc write
        n_cmp++;
        if ({ctl, csr_waddr_o, csr_wdata_o} !== {6'b000101, A_MEPC, 32'h1234}) begin
            n_bad++; $display("FAIL rst_mid_epc: ctl %b waddr %h wdata %h", ctl, csr_waddr_o, csr_wdata_o);
        end
        next_cycle();
        rst = 1'b1;                        // cycle 2: would be T_CAUSE
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ctl, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o} !== '0) begin
                n_bad++;
                $display("FAIL rst_mid c%0d: ctl %b raddr %h waddr %h wdata %h tgt %h want 0",
                         c, ctl, csr_raddr_o, csr_waddr_o, csr_wdata_o, target_pc_o);
            end
            next_cycle();
            rst = 1'b0;
        end
        n_cmp++;
        if ({csr_mem[A_MEPC], csr_mem[A_MCAUSE], csr_mem[A_MSTATUS]} !== {32'h1234, 32'hDEAD, 32'h8}) begin
            n_bad++;
            $display("FAIL rst_mid_csrs: mepc %h mcause %h mstatus %h want 1234 dead 8",
                     csr_mem[A_MEPC], csr_mem[A_MCAUSE], csr_mem[A_MSTATUS]);
        end
        ref_csr[A_MEPC] = 32'h1234;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            set_csr(A_MSTATUS, $urandom);
            set_csr(A_MTVEC, $urandom);
            // No idle gap: each sequence starts the cycle after the previous done.
            test_trap($urandom, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            test_mret();
            test_trap($urandom, $urandom, 1'b1, 1'b0);
            test_trap($urandom, $urandom, 1'b0, 1'b1);
            test_mret();
            test_mret();
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        trap_pc_i = '0; trap_cause_i = '0;
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_exu_rmw();
        test_exu_random();
        // Documented trap / mret vectors
        set_csr(A_MSTATUS, 32'h0000_0008);
        set_csr(A_MTVEC, 32'h8000_0101);
        test_trap(32'h1234, 32'h8000_000B, 1'b0, 1'b0);
        set_csr(A_MEPC, 32'h2000);
        test_mret();
        test_contention();
        test_reset_mid_trap();
        test_trap(32'h0000_4444, 32'h2, 1'b1, 1'b0);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
